// File: rtl/ft245_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ft245_fifo_bridge
// Brief    : Bridges an FT245 synchronous FIFO bus to user-side TX/RX byte
//            streams through two first-word-fall-through buffers, with
//            burst-limited, fairness-aware read/write arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_fifo_bridge #(
   parameter int TX_AW       = 4,
   parameter int RX_AW       = 4,
   parameter int MAX_BURST   = 16,
   parameter int RX_PRIORITY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             _txe,
   input  logic             _rxf,
   output logic             _rd,
   output logic             _wr,
   output logic             _oe,
   inout  wire  [7:0]       data,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [TX_AW:0]   tx_level,
   output logic [RX_AW:0]   rx_level
);

   localparam int             C_TX_DEPTH     = 1 << TX_AW;
   localparam int             C_RX_DEPTH     = 1 << RX_AW;
   localparam logic [TX_AW:0] C_TX_FULL      = (TX_AW + 1)'(C_TX_DEPTH);
   localparam logic [RX_AW:0] C_RX_FULL      = (RX_AW + 1)'(C_RX_DEPTH);
   localparam logic [TX_AW:0] C_TX_LVL_ONE   = (TX_AW + 1)'(1);
   localparam logic [RX_AW:0] C_RX_LVL_ONE   = (RX_AW + 1)'(1);
   localparam logic [TX_AW-1:0] C_TX_PTR_ONE = TX_AW'(1);
   localparam logic [RX_AW-1:0] C_RX_PTR_ONE = RX_AW'(1);
   // A read burst needs room for the byte in flight plus pipeline slack
   localparam logic [RX_AW:0] C_RX_MIN_FREE  = (RX_AW + 1)'(3);
   localparam logic [RX_AW:0] C_RX_EXIT_FREE = (RX_AW + 1)'(2);
   localparam logic [7:0]     C_MAX_BURST    = 8'(MAX_BURST);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_OE  = 3'd1,
      S_READ   = 3'd2,
      S_RD_END = 3'd3,
      S_WRITE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [7:0]       r_tx_mem [C_TX_DEPTH];
   logic [TX_AW-1:0] r_tx_wptr;
   logic [TX_AW-1:0] r_tx_rptr;
   logic [TX_AW:0]   r_tx_level;
   logic [TX_AW:0]   w_tx_level_nxt;
   logic             w_tx_push;
   logic             w_tx_pop;

   logic [7:0]       r_rx_mem [C_RX_DEPTH];
   logic [RX_AW-1:0] r_rx_wptr;
   logic [RX_AW-1:0] r_rx_rptr;
   logic [RX_AW:0]   r_rx_level;
   logic [RX_AW:0]   w_rx_level_nxt;
   logic [RX_AW:0]   w_rx_free;
   logic [RX_AW:0]   w_rx_free_nxt;
   logic             w_rx_push;
   logic             w_rx_pop;

   logic [7:0]       r_burst;
   logic [7:0]       w_burst_nxt;
   logic             w_burst_inc;
   logic             w_burst_clr;
   logic             w_burst_max;

   logic             r_fair;
   logic             r_fair_rd;
   logic             w_fair_set;
   logic             w_fair_dir;
   logic             w_fair_clr;

   logic             w_rd_elig;
   logic             w_wr_elig;
   logic             w_pick_rd;

   // Buffer handshakes and status
   assign tx_ready    = (r_tx_level < C_TX_FULL);
   assign tx_level    = r_tx_level;
   assign rx_valid    = (r_rx_level != '0);
   assign rx_level    = r_rx_level;
   assign rx_data     = r_rx_mem[r_rx_rptr];

   assign w_tx_push   = tx_valid & tx_ready;
   assign w_tx_pop    = (r_state == S_WRITE) && (r_tx_level != '0) && !_txe;
   assign w_rx_push   = (r_state == S_READ) && !_rxf;
   assign w_rx_pop    = rx_valid & rx_ready;

   assign w_rx_free     = C_RX_FULL - r_rx_level;
   assign w_rx_free_nxt = C_RX_FULL - w_rx_level_nxt;

   assign w_burst_inc = w_rx_push | w_tx_pop;
   assign w_burst_nxt = r_burst + 8'd1;
   assign w_burst_max = (w_burst_nxt == C_MAX_BURST);

   assign w_rd_elig   = !_rxf && (w_rx_free >= C_RX_MIN_FREE);
   assign w_wr_elig   = !_txe && (r_tx_level != '0);
   // After a burst was cut at the limit, the other direction wins one tie
   assign w_pick_rd   = r_fair ? !r_fair_rd : (RX_PRIORITY != 0);

   // The FPGA owns the bus only while writing
   assign data = (r_state == S_WRITE) ? r_tx_mem[r_tx_rptr] : 8'hzz;

   // Next buffer occupancy; simultaneous push and pop cancel
   always_comb begin
      w_tx_level_nxt = r_tx_level;
      if (w_tx_push && !w_tx_pop) begin
         w_tx_level_nxt = r_tx_level + C_TX_LVL_ONE;
      end else if (!w_tx_push && w_tx_pop) begin
         w_tx_level_nxt = r_tx_level - C_TX_LVL_ONE;
      end
      w_rx_level_nxt = r_rx_level;
      if (w_rx_push && !w_rx_pop) begin
         w_rx_level_nxt = r_rx_level + C_RX_LVL_ONE;
      end else if (!w_rx_push && w_rx_pop) begin
         w_rx_level_nxt = r_rx_level - C_RX_LVL_ONE;
      end
   end

   // Buffer storage writes (no reset needed on data arrays)
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data;
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= data;
   end

   // Buffer pointers and levels
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_level <= '0;
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_level <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + C_TX_PTR_ONE;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + C_TX_PTR_ONE;
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + C_RX_PTR_ONE;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + C_RX_PTR_ONE;
         r_tx_level <= w_tx_level_nxt;
         r_rx_level <= w_rx_level_nxt;
      end
   end

   // State, burst counter and fairness flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_burst   <= 8'd0;
         r_fair    <= 1'b0;
         r_fair_rd <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_burst_clr) begin
            r_burst <= 8'd0;
         end else if (w_burst_inc) begin
            r_burst <= w_burst_nxt;
         end
         if (w_fair_set) begin
            r_fair    <= 1'b1;
            r_fair_rd <= w_fair_dir;
         end else if (w_fair_clr) begin
            r_fair    <= 1'b0;
         end
      end
   end

   // Arbitration, bus strobes and burst termination
   always_comb begin
      w_state_nxt = r_state;
      _rd         = 1'b1;
      _wr         = 1'b1;
      _oe         = 1'b1;
      w_burst_clr = 1'b0;
      w_fair_set  = 1'b0;
      w_fair_dir  = 1'b0;
      w_fair_clr  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rd_elig && w_wr_elig) begin
               w_fair_clr  = r_fair;
               w_burst_clr = 1'b1;
               w_state_nxt = w_pick_rd ? S_RD_OE : S_WRITE;
            end else if (w_rd_elig) begin
               w_burst_clr = 1'b1;
               w_state_nxt = S_RD_OE;
            end else if (w_wr_elig) begin
               w_burst_clr = 1'b1;
               w_state_nxt = S_WRITE;
            end
         end
         S_RD_OE: begin
            _oe         = 1'b0;
            w_state_nxt = S_READ;
         end
         S_READ: begin
            _oe = 1'b0;
            _rd = 1'b0;
            if (_rxf || (w_rx_free_nxt <= C_RX_EXIT_FREE) ||
                (w_rx_push && w_burst_max)) begin
               w_state_nxt = S_RD_END;
               if (w_rx_push && w_burst_max) begin
                  w_fair_set = 1'b1;
                  w_fair_dir = 1'b1;
               end
            end
         end
         S_RD_END: begin
            w_state_nxt = S_IDLE;
         end
         S_WRITE: begin
            _wr = (r_tx_level == '0);
            if ((w_tx_level_nxt == '0) || _txe || (w_tx_pop && w_burst_max)) begin
               w_state_nxt = S_IDLE;
               if (w_tx_pop && w_burst_max) begin
                  w_fair_set = 1'b1;
                  w_fair_dir = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ft245_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_fifo_bridge
// Brief    : Self-checking bench for ft245_fifo_bridge with a behavioural
//            FT245 device model and TX/RX scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft245_fifo_bridge;

   localparam int TX_AW       = 4;
   localparam int RX_AW       = 2;
   localparam int MAX_BURST   = 4;
   localparam int RX_PRIORITY = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             txe_n;
   logic             rxf_n;
   logic             rd_n;
   logic             wr_n;
   logic             oe_n;
   wire  [7:0]       data;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [TX_AW:0]   tx_level;
   logic [RX_AW:0]   rx_level;

   int               total = 0;
   int               bad   = 0;
   int               cyc   = 0;
   int               wr_cnt = 0;
   int               rx_cnt = 0;

   logic [7:0]       tx_exp [$];
   logic [7:0]       rx_exp [$];
   logic [7:0]       dir_q  [$];
   int               wr_cyc [$];

   // FT245 PC-side byte source
   logic [7:0]       src_mem [64];
   int               src_wr = 0;
   int               src_rd = 0;
   logic             rxf_block;

   logic             prev_rd = 1'b1;
   logic             prev_oe = 1'b1;

   ft245_fifo_bridge #(
      .TX_AW      (TX_AW),
      .RX_AW      (RX_AW),
      .MAX_BURST  (MAX_BURST),
      .RX_PRIORITY(RX_PRIORITY)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      ._txe     (txe_n),
      ._rxf     (rxf_n),
      ._rd      (rd_n),
      ._wr      (wr_n),
      ._oe      (oe_n),
      .data     (data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_level (tx_level),
      .rx_level (rx_level)
   );

   always #5 clk = ~clk;

   // Cycle counter for burst timing checks
   always @(posedge clk) cyc <= cyc + 1;

   // Device model: holds a byte while the source is non-empty, drives it under _oe
   assign rxf_n = rxf_block || (src_rd == src_wr);
   assign data  = !oe_n ? src_mem[src_rd % 64] : 8'hzz;

   // Device model: advance the source on each completed read strobe
   always @(posedge clk) begin
      if (!rd_n && !rxf_n) src_rd <= src_rd + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bus monitor: predicts transfers completed by the next rising edge
   always @(negedge clk) begin
      logic [31:0] e;
      if (!wr_n && !txe_n) begin
         dir_q.push_back(8'h57);  // 'W'
         wr_cyc.push_back(cyc);
         wr_cnt <= wr_cnt + 1;
         e = (tx_exp.size() != 0) ? {24'd0, tx_exp.pop_front()} : 32'h0000_0100;
         check("tx_byte", {24'd0, data}, e);
      end
      if (!rd_n && !rxf_n) dir_q.push_back(8'h52);  // 'R'
      if (rx_valid && rx_ready) begin
         rx_cnt <= rx_cnt + 1;
         e = (rx_exp.size() != 0) ? {24'd0, rx_exp.pop_front()} : 32'h0000_0100;
         check("rx_byte", {24'd0, rx_data}, e);
      end
      if (!wr_n) check("wr_oe_overlap", 32'(oe_n), 32'd1);
      if (prev_rd && !rd_n) check("oe_lead_rd", 32'(prev_oe), 32'd0);
      if (!prev_rd && rd_n) check("rd_turnaround", 32'({oe_n, wr_n}), 32'd3);
      prev_rd <= rd_n;
      prev_oe <= oe_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] b);
      bit ok = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      if (ok) tx_exp.push_back(b);
      check("tx_accept", 32'(ok), 32'd1);
   endtask

   task automatic load_rx(input logic [7:0] b);
      src_mem[src_wr % 64] = b;
      src_wr = src_wr + 1;
      rx_exp.push_back(b);
   endtask

   task automatic drain(input string tag, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_exp.size() == 0 && rx_exp.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check(tag, 32'(done), 32'd1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Global time limit
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n0;
      int span;
      bit found;
      reset     = 1'b1;
      txe_n     = 1'b1;
      rxf_block = 1'b1;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      rx_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", 32'({rd_n, wr_n, oe_n}), 32'd7);
      check("rst_tx_level", 32'(tx_level), 32'd0);
      check("rst_rx_level", 32'(rx_level), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Three-byte write burst
      push_tx(8'h11);
      push_tx(8'h22);
      push_tx(8'h33);
      check("wr3_level_pre", 32'(tx_level), 32'd3);
      wr_cyc.delete();
      txe_n = 1'b0;
      drain("wr3_drain", 50);
      span = (wr_cyc.size() == 3) ? (wr_cyc[2] - wr_cyc[0]) : -1;
      check("wr3_count", 32'(wr_cyc.size()), 32'd3);
      check("wr3_consecutive", 32'(span), 32'd2);
      check("wr3_level_post", 32'(tx_level), 32'd0);
      check("wr3_wr_high", 32'(wr_n), 32'd1);

      // Five-byte read
      n0 = rx_cnt;
      for (int i = 0; i < 5; i++) load_rx(8'hA0 + 8'(i));
      rxf_block = 1'b0;
      drain("rd5_drain", 100);
      check("rd5_count", 32'(rx_cnt - n0), 32'd5);
      check("rd5_rx_level", 32'(rx_level), 32'd0);
      check("rd5_src_empty", 32'(src_wr - src_rd), 32'd0);

      // Write stalled by _txe mid-burst
      txe_n = 1'b1;
      n0 = wr_cnt;
      for (int i = 0; i < 6; i++) push_tx(8'hC0 + 8'(i));
      txe_n = 1'b0;
      tick();
      tick();
      txe_n = 1'b1;
      tick();
      tick();
      check("stall_level", 32'(tx_level), 32'd5);
      check("stall_wr_high", 32'(wr_n), 32'd1);
      txe_n = 1'b0;
      drain("stall_drain", 100);
      check("stall_count", 32'(wr_cnt - n0), 32'd6);

      // RX back-pressure on a 4-deep buffer
      rx_ready = 1'b0;
      n0 = rx_cnt;
      for (int i = 0; i < 8; i++) load_rx(8'hD0 + 8'(i));
      rxf_block = 1'b0;
      repeat (30) tick();
      check("bp_rx_level", 32'(rx_level), 32'd2);
      check("bp_src_left", 32'(src_wr - src_rd), 32'd6);
      check("bp_rd_high", 32'(rd_n), 32'd1);
      check("bp_rx_valid", 32'(rx_valid), 32'd1);
      check("bp_rx_head", 32'(rx_data), 32'hD0);
      rx_ready = 1'b1;
      drain("bp_drain", 200);
      check("bp_count", 32'(rx_cnt - n0), 32'd8);

      // Reset in the middle of a read burst
      rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) load_rx(8'hE0 + 8'(i));
      rxf_block = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!rd_n && rx_level == 1) begin
            found = 1'b1;
            break;
         end
      end
      check("rstrd_in_read", 32'(found), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rstrd_strobes", 32'({rd_n, wr_n, oe_n}), 32'd7);
      check("rstrd_rx_level", 32'(rx_level), 32'd0);
      check("rstrd_rx_valid", 32'(rx_valid), 32'd0);
      rxf_block = 1'b1;
      rx_exp.delete();
      @(posedge clk);
      #1;
      src_wr   = src_rd;
      reset    = 1'b0;
      rx_ready = 1'b1;
      repeat (3) tick();
      check("rstrd_idle", 32'({rd_n, wr_n, oe_n}), 32'd7);

      // Both directions saturated: bursts must alternate R,W at the limit
      txe_n = 1'b1;
      for (int i = 0; i < 16; i++) push_tx(8'h40 + 8'(i));
      for (int i = 0; i < 16; i++) load_rx(8'h80 + 8'(i));
      dir_q.delete();
      txe_n     = 1'b0;
      rxf_block = 1'b0;
      drain("alt_drain", 400);
      check("alt_count", 32'(dir_q.size()), 32'd32);
      for (int i = 0; i < 32; i++) begin
         logic [7:0] want;
         logic [7:0] got;
         want = (((i / MAX_BURST) % 2) == 0) ? 8'h52 : 8'h57;
         got  = (i < dir_q.size()) ? dir_q[i] : 8'h00;
         check($sformatf("alt_dir[%0d]", i), 32'(got), 32'(want));
      end
      check("alt_tx_level", 32'(tx_level), 32'd0);
      check("alt_rx_level", 32'(rx_level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
